// File: rtl/beamscaler_cond_pkg.sv
// Shared types and sizing helpers for the beam scaler trigger conditioning stage.
package beamscaler_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_DONE = 2'd2
  } cond_state_e;

  localparam int DEF_STRETCH      = 4;
  localparam int DEF_TIMER_PERIOD = 1000;
  localparam int STRETCH_BITS     = $clog2(DEF_STRETCH + 1);
  localparam int TIMER_BITS       = $clog2(DEF_TIMER_PERIOD);

  function automatic int nch(input int nbeams, input int nscalers);
    return nbeams * nscalers;
  endfunction

  function automatic int stretch_bits(input int stretch);
    return $clog2(stretch + 1);
  endfunction

  function automatic int timer_bits(input int period);
    return $clog2(period);
  endfunction

endpackage

// File: rtl/trig_stretch_ch.sv
// One trigger channel: mask, one-cycle history and a minimum-width stretch counter.
module trig_stretch_ch
  import beamscaler_cond_pkg::*;
#(
  parameter int STRETCH = 4
) (
  input  logic ifclk_i,
  input  logic rst_n_i,
  input  logic trig_i,
  input  logic mask_i,
  output logic count_o
);

  localparam int SB = stretch_bits(STRETCH);

  logic          t;
  logic          r_q;
  logic [SB-1:0] cnt_q, cnt_d;

  // Reloading on every high cycle covers the rising edge and makes a held
  // level trail by STRETCH-1 cycles; a mask kills the pulse at once.
  always_comb begin
    t     = trig_i & ~mask_i;
    cnt_d = cnt_q;
    if (mask_i)               cnt_d = '0;
    else if (t)               cnt_d = SB'(STRETCH);
    else if (cnt_q != '0)     cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge ifclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      r_q   <= t;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = (cnt_q != '0) | r_q;

endmodule

// File: rtl/beamscaler_trig_cond.sv
// Trigger conditioning, scaler gate timer and done-handshake tracking for the
// beam scaler bank, all in the ifclk domain.
module beamscaler_trig_cond
  import beamscaler_cond_pkg::*;
#(
  parameter int NBEAMS       = 46,
  parameter int NSCALERS     = 2,
  parameter int STRETCH      = 4,
  parameter int TIMER_PERIOD = 1000,
  localparam int NCH         = nch(NBEAMS, NSCALERS)
) (
  input  logic            ifclk_i,
  input  logic            rst_n_i,
  input  logic [NCH-1:0]  trig_i,
  input  logic [NCH-1:0]  mask_i,
  input  logic            en_i,
  input  logic            done_i,
  output logic [NCH-1:0]  count_o,
  output logic            timer_o,
  output logic [15:0]     period_cnt_o,
  output logic            overrun_o
);

  localparam int               TB     = timer_bits(TIMER_PERIOD);
  localparam logic [TB-1:0]    T_LAST = TB'(TIMER_PERIOD - 1);

  localparam logic [1:0] S_IDLE      = ST_IDLE;
  localparam logic [1:0] S_RUN       = ST_RUN;
  localparam logic [1:0] S_WAIT_DONE = ST_WAIT_DONE;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    trig_stretch_ch #(.STRETCH(STRETCH)) u_ch (
      .ifclk_i (ifclk_i),
      .rst_n_i (rst_n_i),
      .trig_i  (trig_i[c]),
      .mask_i  (mask_i[c]),
      .count_o (count_o[c])
    );
  end

  logic [1:0]    state_q, state_d;
  logic [TB-1:0] tcnt_q, tcnt_d;
  logic          timer_q, timer_d;
  logic [15:0]   period_q, period_d;
  logic          ovr_q, ovr_d;

  // The FSM reacts to the registered gate pulse, so it sees the same pulse
  // the scaler bank does.
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    timer_d  = 1'b0;
    period_d = period_q;
    ovr_d    = ovr_q;
    if (!en_i) begin
      state_d = S_IDLE;
      tcnt_d  = '0;
      ovr_d   = 1'b0;
    end else begin
      if (state_q != S_IDLE) begin
        timer_d = (tcnt_q == T_LAST);
        tcnt_d  = (tcnt_q == T_LAST) ? '0 : tcnt_q + 1'b1;
      end
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   if (timer_q) state_d = S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (done_i) begin
            period_d = period_q + 16'd1;
            if (!timer_q) state_d = S_RUN;
          end else if (timer_q) begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ifclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      tcnt_q   <= '0;
      timer_q  <= 1'b0;
      period_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      ovr_q    <= ovr_d;
    end
  end

  assign timer_o      = timer_q;
  assign period_cnt_o = period_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_beamscaler_trig_cond.sv
// Directed bench for beamscaler_trig_cond with a cycle-level reference model.
module tb_beamscaler_trig_cond;

  localparam int NB  = 46;
  localparam int NS  = 2;
  localparam int NCH = NB * NS;
  localparam int S   = 4;
  localparam int P   = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           done = 1'b0;
  logic [NCH-1:0] trig = '0;
  logic [NCH-1:0] mask = '0;
  logic [NCH-1:0] count;
  logic           timer;
  logic           ovr;
  logic [15:0]    pcnt;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int preset_seq = 0;

  beamscaler_trig_cond #(
    .NBEAMS(NB), .NSCALERS(NS), .STRETCH(S), .TIMER_PERIOD(P)
  ) dut (
    .ifclk_i      (clk),
    .rst_n_i      (rst_n),
    .trig_i       (trig),
    .mask_i       (mask),
    .en_i         (en),
    .done_i       (done),
    .count_o      (count),
    .timer_o      (timer),
    .period_cnt_o (pcnt),
    .overrun_o    (ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a channel is high at cycle n if it was unmasked-high at some
  // cycle in [n-S, n-1] and no mask came after that. The timer fires every P
  // cycles, the first P+1 cycles after en is first sampled high.
  int             last_t [NCH];
  int             last_m [NCH];
  int             run_s = -1;
  bit             pend = 1'b0;
  bit             m_ovr = 1'b0;
  logic [15:0]    m_cnt = '0;
  logic [NCH-1:0] e_count = '0;
  bit             e_timer = 1'b0;
  int             preset_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin last_t[c] = -100; last_m[c] = -100; end
      run_s = -1; pend = 1'b0; m_ovr = 1'b0; m_cnt = '0; e_count = '0; e_timer = 1'b0;
    end
    if (preset_seq != preset_seen) begin
      preset_seen = preset_seq;
      m_cnt = 16'hFFFF;
    end
    chk("count_o", count, e_count);
    chk("timer_o", timer, e_timer);
    chk("period_cnt_o", pcnt, m_cnt);
    chk("overrun_o", ovr, m_ovr);
    if (rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        if (trig[c] && !mask[c]) last_t[c] = cyc;
        if (mask[c]) last_m[c] = cyc;
        e_count[c] = (last_t[c] >= cyc + 1 - S) && (last_m[c] < last_t[c]);
      end
      if (!en) begin
        pend = 1'b0; m_ovr = 1'b0;
      end else if (e_timer) begin
        if (pend) begin
          if (done) m_cnt = m_cnt + 16'd1;
          else      m_ovr = 1'b1;
        end else pend = 1'b1;
      end else if (pend && done) begin
        m_cnt = m_cnt + 16'd1; pend = 1'b0;
      end
      if (!en) run_s = -1;
      else if (run_s < 0) run_s = cyc;
      e_timer = (run_s >= 0) && (cyc - run_s >= P) && ((cyc - run_s) % P == 0);
    end
  end

  task automatic at(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  logic [7:0]     tv [16];
  logic [NCH-1:0] sel05;

  initial begin
    tv = '{8'h01, 8'h03, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h00,
           8'h55, 8'hAA, 8'h00, 8'h10, 8'h10, 8'h00, 8'h00, 8'h0F};
    sel05 = '0; sel05[0] = 1'b1; sel05[5] = 1'b1;

    at(2);
    chk("rst count", count, '0); chk("rst timer", timer, 0);
    chk("rst pcnt", pcnt, 0);    chk("rst ovr", ovr, 0);
    at(3); rst_n = 1'b1;

    // single pulse on ch5, double pulse on ch0
    at(110); trig[5] = 1'b1; trig[0] = 1'b1; chk("ch5 before", count[5], 0);
    at(111); trig[5] = 1'b0; trig[0] = 1'b0; chk("ch5 first", count[5], 1);
    at(112); trig[0] = 1'b1; chk("others quiet", count & ~sel05, '0);
    at(113); trig[0] = 1'b0;
    at(114); chk("ch5 last", count[5], 1);
    at(115); chk("ch5 end", count[5], 0); chk("ch0 held", count[0], 1);
    at(116); chk("ch0 last", count[0], 1);
    at(117); chk("ch0 end", count[0], 0);

    // held level on ch91
    at(220); trig[91] = 1'b1; chk("ch91 before", count[91], 0);
    at(221); chk("ch91 rise", count[91], 1);
    at(250); trig[91] = 1'b0;
    at(253); chk("ch91 tail", count[91], 1);
    at(254); chk("ch91 end", count[91], 0);

    // mask mid-stretch
    at(320); trig[91] = 1'b1;
    at(330); mask[91] = 1'b1; chk("ch91 premask", count[91], 1);
    at(331); chk("ch91 masked", count[91], 0);
    at(335); chk("ch91 stays", count[91], 0);
    at(350); trig[91] = 1'b0; mask[91] = 1'b0;

    // multi-channel pattern table
    for (int i = 0; i < 16; i++) begin
      at(400 + i);
      trig[47:40] = tv[i];
      mask[47:44] = (i == 5 || i == 6) ? 4'hF : ((i == 12) ? 4'h1 : 4'h0);
    end
    at(416); trig[47:40] = '0; mask[47:44] = '0;

    // timer, done, coincident done, overrun, disable
    at(1000); en = 1'b1;
    at(1008); chk("tmr pre", timer, 0);
    at(1009); chk("tmr 1st", timer, 1);
    at(1010); chk("tmr off", timer, 0);
    at(1012); done = 1'b1; chk("pcnt pre", pcnt, 0);
    at(1013); done = 1'b0; chk("pcnt 1", pcnt, 1); chk("ovr 0", ovr, 0);
    at(1017); chk("tmr 2nd", timer, 1);
    at(1025); done = 1'b1; chk("tmr 3rd", timer, 1);
    at(1026); done = 1'b0; chk("pcnt coinc", pcnt, 2); chk("ovr coinc", ovr, 0);
    at(1033); chk("tmr 4th", timer, 1); chk("ovr pre", ovr, 0);
    at(1034); chk("ovr set", ovr, 1);
    at(1036); done = 1'b1;
    at(1037); done = 1'b0; chk("pcnt 3", pcnt, 3); chk("ovr sticky", ovr, 1);
    at(1040); en = 1'b0;
    at(1041); chk("ovr clr", ovr, 0); chk("pcnt kept", pcnt, 3); chk("tmr idle", timer, 0);

    // overrun straight after the first period
    at(1100); en = 1'b1;
    at(1109); chk("tmr E1", timer, 1);
    at(1117); chk("tmr E2", timer, 1); chk("ovr E pre", ovr, 0);
    at(1118); chk("ovr E", ovr, 1);
    at(1120); en = 1'b0;
    at(1121); chk("ovr E clr", ovr, 0); chk("pcnt E", pcnt, 3);

    // counter wrap from a preset value
    at(1200); en = 1'b1;
    at(1211); force dut.period_q = 16'hFFFF; preset_seq++;
    at(1212); #1 release dut.period_q;
    chk("pcnt preset", pcnt, 16'hFFFF);
    at(1213); done = 1'b1;
    at(1214); done = 1'b0; chk("pcnt wrap", pcnt, 0);
    at(1220); done = 1'b1;
    at(1221); done = 1'b0; chk("pcnt F", pcnt, 1);

    // asynchronous reset mid-stretch, mid-period, with overrun set
    at(1234); trig[5] = 1'b1; chk("ovr F", ovr, 1);
    at(1235); trig[5] = 1'b0;
    at(1236); chk("ch5 mid", count[5], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async count", count, '0); chk("async pcnt", pcnt, 0);
    chk("async ovr", ovr, 0);      chk("async timer", timer, 0);
    at(1239); rst_n = 1'b1;
    at(1247); chk("tmr post pre", timer, 0);
    at(1248); chk("tmr post rst", timer, 1);
    at(1250); en = 1'b0;
    at(1260);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/beamscaler_trig_cond.md
Name: beamscaler_trig_cond

Overview:
- Upstream conditioning stage for the beam scaler WISHBONE wrapper, running entirely in IFCLK.
- Takes raw per-beam, per-scaler L1 trigger pulses and stretches them to a guaranteed minimum width, applying a per-channel mask.
- Produces the periodic scaler gate pulse (timer) consumed by the scaler bank.
- Tracks the bank's done handshake, counts completed scaler periods and flags overruns.

Parameters:
- NBEAMS, 46, number of beams.
- NSCALERS, 2, scalers per beam; NCH = NBEAMS*NSCALERS channels.
- STRETCH, 4, minimum output width in ifclk cycles (1..15).
- TIMER_PERIOD, 1000, ifclk cycles per scaler period (>= 4).

Ports:
- ifclk_i  in  1  sole clock.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- trig_i  in  NCH  raw trigger levels or pulses, one bit per channel.
- mask_i  in  NCH  1 = channel suppressed.
- en_i  in  1  timer/period enable (level).
- done_i  in  1  one-cycle pulse from the scaler bank: period's counts transferred.
- count_o  out  NCH  conditioned trigger to the scaler wrapper.
- timer_o  out  1  one-cycle scaler gate pulse.
- period_cnt_o  out  16  completed-period count.
- overrun_o  out  1  sticky: timer fired before the previous done.

Behaviour:
- Reset (rst_n_i low, asynchronous): all outputs 0, all counters 0, FSM in IDLE, trig history registers 0.
- Channel path, identical for each bit c:
  - t_c = trig_i[c] & ~mask_i[c], registered once as r_c.
  - Rising edge = t_c & ~r_c.
  - Edge at cycle N: stretch counter loads STRETCH at N+1, so count_o[c] is high for cycles N+1 .. N+STRETCH.
  - count_o[c] = (stretch counter != 0) | r_c. A level held high therefore keeps the output high for its full duration plus STRETCH-1 extra cycles. Counter decrements to 0 and saturates there.
  - A new rising edge while stretching reloads STRETCH, extending the pulse; no gap is produced.
  - mask_i[c] asserting mid-stretch: counter cleared and count_o[c] low from the next cycle.
- Timer:
  - Counter tcnt runs 0..TIMER_PERIOD-1 while the FSM is not IDLE.
  - timer_o is a registered pulse, high for the one cycle after tcnt == TIMER_PERIOD-1; tcnt wraps to 0.
  - First timer_o occurs TIMER_PERIOD+1 cycles after en_i is sampled high.
- FSM states: IDLE, RUN, WAIT_DONE.
  - IDLE: tcnt held at 0, timer_o 0. en_i sampled high -> RUN.
  - RUN: timer pulse -> WAIT_DONE. done_i is ignored.
  - WAIT_DONE: done_i -> period_cnt_o += 1 (16-bit wrap, 0xFFFF -> 0x0000), return to RUN.
  - WAIT_DONE, timer pulse without done_i: overrun_o set (sticky); remain in WAIT_DONE.
  - WAIT_DONE, done_i and timer pulse in the same cycle: period_cnt_o increments, stay in WAIT_DONE for the new period, overrun_o not set.
  - en_i sampled low in any state: IDLE next cycle; tcnt cleared; overrun_o cleared; period_cnt_o retained.
- Latency summary: trig -> count_o is 1 cycle. done_i -> period_cnt_o is 1 cycle.

Decomposition:
- Package beamscaler_cond_pkg holds:
  - FSM state enum (IDLE/RUN/WAIT_DONE).
  - Helper function nch(NBEAMS,NSCALERS).
  - STRETCH_BITS = $clog2(STRETCH+1).
  - TIMER_BITS = $clog2(TIMER_PERIOD).
- Sub-module trig_stretch_ch: a single channel (edge detect, mask, stretch counter), generated NCH times.
- The timer and FSM stay in the top level.

Test Plan:
- Single 1-cycle pulse on ch 5, STRETCH=4, pulse at cycle 10 -> count_o[5] high cycles 11-14 only; all other channels stay 0.
- Retrigger: ch 0 pulses at cycles 10 and 12 -> count_o[0] high continuously for cycles 11-16.
- Level hold: ch 91 high for cycles 20-49 -> count_o[91] high for cycles 21-53. Assert mask_i[91] at cycle 30 -> output low from cycle 31.
- Timer and done, TIMER_PERIOD=8: en_i high at cycle 0 -> timer_o at cycles 9, 17, 25. done_i at cycle 12 -> period_cnt_o = 1 at cycle 13, overrun_o stays 0.
- Overrun: no done_i after the cycle-9 pulse -> overrun_o = 1 at cycle 18. Drop en_i -> overrun_o = 0 and period_cnt_o unchanged.
- Corner cases:
  - done_i coincident with timer_o -> count increments, overrun_o stays 0.
  - period_cnt_o preset-driven to 0xFFFF, then one done_i -> wraps to 0.
  - rst_n_i pulsed low mid-stretch and mid-period -> all outputs 0 immediately, without waiting for a clock edge.
